// File: rtl/button_multi_debounce.sv
// N-channel push-button front end: synchroniser, stable-count debounce,
// press/release event pulses, long-press detection and auto-repeat per channel.
module button_multi_debounce #(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200,
  parameter int REPEAT_EN       = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] debounced,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HELD, LONG} hold_state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   deb_q, press_q, release_q, long_q, repeat_q;
    logic [DW-1:0]          db_cnt;
    logic [HW-1:0]          hold_cnt, hold_cnt_d;
    logic [RW-1:0]          rep_cnt, rep_cnt_d;
    hold_state_e            state_q, state_d;
    logic                   rise, fall, long_d, repeat_d;

    assign s    = sync_q[SYNC_STAGES-1];
    // The accepting edge is the one where the new level has already been
    // seen for DEBOUNCE_CYCLES-1 edges; that edge toggles the filtered level.
    assign rise = (s != deb_q) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) && !deb_q;
    assign fall = (s != deb_q) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) &&  deb_q;

    always_comb begin
      // NOTE: every output of this block gets a default first, so no branch can leave a latch.
      state_d    = state_q;
      hold_cnt_d = hold_cnt;
      rep_cnt_d  = rep_cnt;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            state_d    = HELD;
            hold_cnt_d = HW'(1);
          end
        end
        HELD: begin
          if (fall) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt == HW'(LONG_CYCLES)) begin
            // Hold counter stays at LONG_CYCLES from here on.
            state_d   = LONG;
            long_d    = 1'b1;
            rep_cnt_d = RW'(1);
          end else begin
            hold_cnt_d = hold_cnt + HW'(1);
          end
        end
        LONG: begin
          if (fall) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
          end else if (rep_cnt == RW'(REPEAT_CYCLES)) begin
            repeat_d  = (REPEAT_EN != 0);
            rep_cnt_d = RW'(1);
          end else begin
            rep_cnt_d = rep_cnt + RW'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
      if (!rst) begin
        sync_q    <= '0;
        deb_q     <= 1'b0;
        db_cnt    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        hold_cnt  <= '0;
        rep_cnt   <= '0;
        state_q   <= IDLE;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], btn[i]};
        press_q   <= rise;
        release_q <= fall;
        if (rise || fall) begin
          deb_q  <= ~deb_q;
          db_cnt <= '0;
        end else if (s != deb_q) begin
          db_cnt <= db_cnt + DW'(1);
        end else begin
          db_cnt <= '0;
        end
        long_q   <= long_d;
        repeat_q <= repeat_d;
        hold_cnt <= hold_cnt_d;
        rep_cnt  <= rep_cnt_d;
        state_q  <= state_d;
      end
    end

    assign debounced[i]     = deb_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = release_q;
    assign long_pulse[i]    = long_q;
    assign repeat_pulse[i]  = repeat_q;
  end

endmodule

// File: tb/tb_button_multi_debounce.sv
// Scoreboard bench for button_multi_debounce: clean edges schedule their
// expected events by the documented latencies; every cycle compares all outputs.
module tb_button_multi_debounce;

  localparam int N   = 4;
  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int LC  = 20;
  localparam int RC  = 5;
  localparam int LAT = SS + DB;
  localparam int HORIZON = 30;

  typedef enum int {EV_PRESS, EV_RELEASE, EV_LONG, EV_REPEAT} ev_kind_e;
  typedef struct {
    int       cyc;
    ev_kind_e kind;
    int       ch;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] debounced, press_pulse, release_pulse, long_pulse, repeat_pulse;

  ev_t          sb[$];
  logic [N-1:0] exp_deb;
  int           cyc = 0;
  int           n_tests = 0;
  int           n_fail = 0;

  button_multi_debounce #(
    .N_BTN(N), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LC), .REPEAT_CYCLES(RC), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .debounced(debounced), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, pop due events, compare.
  task automatic tick();
    logic [N-1:0] ep, er, el, erp;
    @(posedge clk);
    #1;
    cyc++;
    ep = '0; er = '0; el = '0; erp = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        case (sb[i].kind)
          EV_PRESS:   begin ep[sb[i].ch] = 1'b1; exp_deb[sb[i].ch] = 1'b1; end
          EV_RELEASE: begin er[sb[i].ch] = 1'b1; exp_deb[sb[i].ch] = 1'b0; end
          EV_LONG:    el[sb[i].ch]  = 1'b1;
          default:    erp[sb[i].ch] = 1'b1;
        endcase
        sb.delete(i);
      end
    end
    check("debounced", 32'(debounced),     32'(exp_deb));
    check("press",     32'(press_pulse),   32'(ep));
    check("release",   32'(release_pulse), 32'(er));
    check("long",      32'(long_pulse),    32'(el));
    check("repeat",    32'(repeat_pulse),  32'(erp));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // A clean rising level sampled from the next edge: press after LAT edges,
  // long LC later, repeats every RC after that (pruned on release).
  task automatic push_press(input int ch);
    int p;
    p = cyc + LAT;
    sb.push_back('{p, EV_PRESS, ch});
    sb.push_back('{p + LC, EV_LONG, ch});
    for (int k = 1; k <= HORIZON; k++) sb.push_back('{p + LC + k * RC, EV_REPEAT, ch});
  endtask

  task automatic push_release(input int ch);
    int r;
    r = cyc + LAT;
    sb.push_back('{r, EV_RELEASE, ch});
    for (int i = sb.size() - 1; i >= 0; i--)
      if (sb[i].ch == ch && (sb[i].kind == EV_LONG || sb[i].kind == EV_REPEAT) && sb[i].cyc >= r)
        sb.delete(i);
  endtask

  task automatic drive(input int ch, input logic v);
    btn[ch] = v;
    if (v) push_press(ch);
    else   push_release(ch);
  endtask

  // Reset clears every output on its first edge, with no release events.
  task automatic assert_reset();
    rst = 1'b0;
    sb.delete();
    exp_deb = '0;
  endtask

  initial begin
    int t0, p;
    exp_deb = '0;
    btn     = 4'hF;
    assert_reset();

    // 1: reset with all buttons held, then a real press on every channel
    ticks(3);
    rst = 1'b1;
    for (int c = 0; c < N; c++) push_press(c);
    ticks(16);
    for (int c = 0; c < N; c++) drive(c, 1'b0);
    ticks(12);

    // 2: glitch of 3 cycles on channel 0 is rejected
    btn[0] = 1'b1;
    ticks(3);
    btn[0] = 1'b0;
    ticks(12);

    // 3: clean press/release on channel 1, no long press
    drive(1, 1'b1);
    ticks(10);
    drive(1, 1'b0);
    ticks(12);

    // 4: long press with auto-repeat on channel 2
    p = cyc + LAT;
    drive(2, 1'b1);
    while (cyc < p + 36) tick();
    drive(2, 1'b0);
    ticks(20);

    // 5: bouncing channel 3 alongside a clean press on channel 1
    t0 = cyc;
    drive(1, 1'b1);
    for (int k = 0; k < 12; k++) begin
      btn[3] = ((k / 2) % 2 == 0);
      if (k == 10) drive(1, 1'b0);
      tick();
    end
    check("bounce_len", 32'(cyc - t0), 32'd12);
    drive(3, 1'b1);
    ticks(10);
    drive(3, 1'b0);
    ticks(12);

    // 6: reset mid-hold on channel 2, button still held afterwards
    p = cyc + LAT;
    drive(2, 1'b1);
    while (cyc < p + 21) tick();
    assert_reset();
    ticks(2);
    rst = 1'b1;
    push_press(2);
    ticks(10);
    drive(2, 1'b0);
    ticks(12);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
